// File: rtl/serial_operand_feeder.sv
// Upstream feeder for the bit-serial adder: takes one {A,B,P} set per valid/ready handshake and
// streams it LSB-first with first/last framing. Define SERIAL_FEEDER_SKID_EN for back-to-back words.
module serial_operand_feeder #(
  parameter int W = 16
) (
  input  logic         CLK_i,
  input  logic         rst_i,
  input  logic [W-1:0] A_i,
  input  logic [W-1:0] B_i,
  input  logic         P_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         stall_i,
  output logic         a_bit_o,
  output logic         b_bit_o,
  output logic         c_bit_o,
  output logic         bit_valid_o,
  output logic         first_o,
  output logic         last_o,
  output logic         busy_o
);

  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [W-1:0]     a_sr_r, a_sr_s, b_sr_r, b_sr_s;
  logic             p_r, p_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             accept_s, consume_s, last_bit_s, boundary_s;

`ifdef SERIAL_FEEDER_SKID_EN
  logic [W-1:0] a_hold_r, a_hold_s, b_hold_r, b_hold_s;
  logic         p_hold_r, p_hold_s, hold_full_r, hold_full_s;
  logic         reload_s;

  assign ready_o  = !rst_i && !hold_full_r;
  assign reload_s = boundary_s && hold_full_r;
`else
  assign ready_o  = !rst_i && (state_r == IDLE);
`endif

  assign accept_s   = valid_i && ready_o;
  assign consume_s  = (state_r == SHIFT) && !stall_i;
  assign last_bit_s = (cnt_r == CNT_LAST);
  // Shift registers are free to take a new word next cycle
  assign boundary_s = (state_r == IDLE) || (consume_s && last_bit_s);

  // Next-state, shift and load decode
  always_comb begin
    state_s = state_r;
    a_sr_s  = a_sr_r;
    b_sr_s  = b_sr_r;
    p_s     = p_r;
    cnt_s   = cnt_r;
`ifdef SERIAL_FEEDER_SKID_EN
    if (reload_s) begin
      a_sr_s  = a_hold_r;
      b_sr_s  = b_hold_r;
      p_s     = p_hold_r;
      cnt_s   = '0;
      state_s = SHIFT;
    end else
`endif
    if (boundary_s && accept_s) begin
      a_sr_s  = A_i;
      b_sr_s  = B_i;
      p_s     = P_i;
      cnt_s   = '0;
      state_s = SHIFT;
    end else if (consume_s && last_bit_s) begin
      a_sr_s  = a_sr_r >> 1;
      b_sr_s  = b_sr_r >> 1;
      cnt_s   = '0;
      state_s = IDLE;
    end else if (consume_s) begin
      a_sr_s  = a_sr_r >> 1;
      b_sr_s  = b_sr_r >> 1;
      cnt_s   = cnt_r + CNT_W'(1);
      state_s = SHIFT;
    end else begin
      state_s = state_r;
    end
  end

  // State, shift registers and bit counter
  always_ff @(posedge CLK_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      p_r     <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      a_sr_r  <= a_sr_s;
      b_sr_r  <= b_sr_s;
      p_r     <= p_s;
      cnt_r   <= cnt_s;
    end
  end

`ifdef SERIAL_FEEDER_SKID_EN
  // Holding register: takes an accept the shift regs cannot, drained by reload
  always_comb begin
    a_hold_s    = a_hold_r;
    b_hold_s    = b_hold_r;
    p_hold_s    = p_hold_r;
    hold_full_s = hold_full_r;
    if (accept_s && !boundary_s) begin
      a_hold_s    = A_i;
      b_hold_s    = B_i;
      p_hold_s    = P_i;
      hold_full_s = 1'b1;
    end else if (reload_s) begin
      hold_full_s = 1'b0;
    end else begin
      hold_full_s = hold_full_r;
    end
  end

  // Holding register storage
  always_ff @(posedge CLK_i or posedge rst_i) begin
    if (rst_i) begin
      a_hold_r    <= '0;
      b_hold_r    <= '0;
      p_hold_r    <= 1'b0;
      hold_full_r <= 1'b0;
    end else begin
      a_hold_r    <= a_hold_s;
      b_hold_r    <= b_hold_s;
      p_hold_r    <= p_hold_s;
      hold_full_r <= hold_full_s;
    end
  end
`endif

  assign busy_o      = (state_r == SHIFT);
  assign bit_valid_o = busy_o;
  assign a_bit_o     = busy_o && a_sr_r[0];
  assign b_bit_o     = busy_o && b_sr_r[0];
  assign first_o     = busy_o && (cnt_r == '0);
  assign last_o      = busy_o && last_bit_s;
  assign c_bit_o     = first_o && p_r;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed self-checking bench for serial_operand_feeder (W=16 instance plus a W=1 instance).
`timescale 1ns/1ps
module tb_serial_operand_feeder;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [W-1:0]  a_in, b_in;
  logic          p_in, valid, stall;
  logic          ready, a_bit, b_bit, c_bit, bit_valid, first, last, busy;
  logic          a1_in, b1_in, p1_in, valid1, stall1;
  logic          ready1, a1_bit, b1_bit, c1_bit, bit_valid1, first1, last1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  serial_operand_feeder #(.W(W)) dut (
    .CLK_i(clk), .rst_i(rst), .A_i(a_in), .B_i(b_in), .P_i(p_in), .valid_i(valid),
    .ready_o(ready), .stall_i(stall), .a_bit_o(a_bit), .b_bit_o(b_bit), .c_bit_o(c_bit),
    .bit_valid_o(bit_valid), .first_o(first), .last_o(last), .busy_o(busy)
  );

  serial_operand_feeder #(.W(1)) dut1 (
    .CLK_i(clk), .rst_i(rst), .A_i(a1_in), .B_i(b1_in), .P_i(p1_in), .valid_i(valid1),
    .ready_o(ready1), .stall_i(stall1), .a_bit_o(a1_bit), .b_bit_o(b1_bit), .c_bit_o(c1_bit),
    .bit_valid_o(bit_valid1), .first_o(first1), .last_o(last1), .busy_o(busy1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference bit-serial adder: returns {carry_out, sum}
  function automatic logic [16:0] serial_add(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin);
    logic [15:0] s;
    logic        c;
    c = cin;
    for (int i = 0; i < 16; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    return {c, s};
  endfunction

  // Offer one word from IDLE, then follow it bit by bit; stall_i high for stall_len cycles from stall_start
  task automatic run_word(input logic [15:0] a, input logic [15:0] b, input logic p,
                          input int stall_start, input int stall_len,
                          output int cycles, output logic [15:0] ra, output logic [15:0] rb,
                          output logic c0, output int ferr);
    int   idx;
    logic done;
    a_in = a; b_in = b; p_in = p; valid = 1'b1;
    idx = 0; cycles = 0; ferr = 0; ra = '0; rb = '0; c0 = 1'b0; done = 1'b0;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      valid  = 1'b0;
      cycles = cyc;
      stall  = (cyc >= stall_start) && (cyc < stall_start + stall_len);
      if (!bit_valid || a_bit !== a[idx] || b_bit !== b[idx] || first !== (idx == 0) ||
          last !== (idx == W - 1) || c_bit !== ((idx == 0) ? p : 1'b0))
        ferr++;
      if (bit_valid && !stall) begin
        ra[idx] = a_bit;
        rb[idx] = b_bit;
        if (idx == 0) c0 = c_bit;
        if (last) done = 1'b1;
        else idx++;
      end
    end
    stall = 1'b0;
    if (!done) ferr++;
  endtask

  initial begin
    int          cycles, ferr, words, idx, w2_cyc, rdy_err;
    logic [15:0] ra, rb, wa1, wa2;
    logic        c0, acc, done;
    logic [16:0] res;
    logic        s1, co1;

    rst = 1'b1; a_in = '0; b_in = '0; p_in = 1'b0; valid = 1'b0; stall = 1'b0;
    a1_in = 1'b0; b1_in = 1'b0; p1_in = 1'b0; valid1 = 1'b0; stall1 = 1'b0;

    @(negedge clk);
    check_val("rst_ready", ready, 1'b0);
    check_val("rst_outs", {bit_valid, busy, first, last, a_bit, b_bit, c_bit}, 7'b0);
    check_val("rst_ready_w1", ready1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_ready", ready, 1'b1);
    check_val("idle_busy", {busy, bit_valid}, 2'b00);

    // Test 1: plain word
    run_word(16'h00FF, 16'h0F0F, 1'b1, 0, 0, cycles, ra, rb, c0, ferr);
    check_val("t1_cycles", cycles, 16);
    check_val("t1_frame", ferr, 0);
    check_val("t1_a", ra, 16'h00FF);
    check_val("t1_b", rb, 16'h0F0F);
    check_val("t1_cin", c0, 1'b1);
    res = serial_add(ra, rb, c0);
    check_val("t1_sum", res, 17'h0100F);
    @(negedge clk);
    check_val("t1_gap", bit_valid, 1'b0);

    // Test 2: three-cycle stall while bit 5 is presented
    run_word(16'h00FF, 16'h0F0F, 1'b1, 6, 3, cycles, ra, rb, c0, ferr);
    check_val("t2_cycles", cycles, 19);
    check_val("t2_frame", ferr, 0);
    check_val("t2_ab", {ra, rb}, 32'h00FF0F0F);
    @(negedge clk);
    check_val("t2_gap", bit_valid, 1'b0);

    // Tests 3 and 5: second word offered with valid held high
    a_in = 16'h00FF; b_in = 16'h0F0F; p_in = 1'b1; valid = 1'b1;
    words = 0; idx = 0; w2_cyc = 0; rdy_err = 0; acc = 1'b0; done = 1'b0; wa1 = '0; wa2 = '0;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        a_in = 16'h8001; b_in = 16'h7FFE; p_in = 1'b0;
      end else if (acc) begin
        valid = 1'b0;
      end
      acc = valid && ready;
      if (bit_valid) begin
        if (first) begin
          words++;
          idx = 0;
          if (words == 2) w2_cyc = cyc;
        end
        if (words == 1) wa1[idx] = a_bit;
        else if (words == 2) wa2[idx] = a_bit;
        if (words == 2 && last) done = 1'b1;
        idx++;
`ifndef SERIAL_FEEDER_SKID_EN
        if (ready) rdy_err++;
`endif
      end
    end
    valid = 1'b0;
    check_val("t3_done", done, 1'b1);
`ifdef SERIAL_FEEDER_SKID_EN
    check_val("t3_w2_start", w2_cyc, 17);
`else
    check_val("t3_w2_start", w2_cyc, 18);
`endif
    check_val("t3_w1_a", wa1, 16'h00FF);
    check_val("t3_w2_a", wa2, 16'h8001);
    check_val("t5_ready_in_shift", rdy_err, 0);
    @(negedge clk);
    check_val("t3_gap", bit_valid, 1'b0);

    // Test 4: reset during bit 8, then a fresh word
    a_in = 16'hFFFF; b_in = 16'h0000; p_in = 1'b0; valid = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    check_val("t4_bit8", {bit_valid, first, last, a_bit}, 4'b1001);
    rst = 1'b1;
    #1;
    check_val("t4_rst_outs", {bit_valid, busy, ready, first, last}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("t4_after_rst", {bit_valid, busy, ready}, 3'b001);
    run_word(16'h0001, 16'h0000, 1'b0, 0, 0, cycles, ra, rb, c0, ferr);
    check_val("t4_frame", ferr, 0);
    check_val("t4_a", ra, 16'h0001);
    check_val("t4_cycles", cycles, 16);
    @(negedge clk);

    // Test 6: single-bit word
    a1_in = 1'b1; b1_in = 1'b1; p1_in = 1'b1; valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    check_val("t6_bit", {bit_valid1, first1, last1, a1_bit, b1_bit, c1_bit}, 6'b111111);
    s1  = a1_bit ^ b1_bit ^ c1_bit;
    co1 = (a1_bit & b1_bit) | (a1_bit & c1_bit) | (b1_bit & c1_bit);
    check_val("t6_sum", {co1, s1}, 2'b11);
    @(negedge clk);
    check_val("t6_done", {bit_valid1, busy1}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
